// File: rtl/ahb_crypto_slave_if.sv
// AHB-Lite bus bundle for ahb_crypto_slave; master drives the transfer, slave returns data/response.
interface ahb_crypto_slave_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32
);
  logic              HSEL;
  logic              HWRITE;
  logic              HREADY;
  logic              HMASTLOCK;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSEL, HWRITE, HMASTLOCK, HTRANS, HSIZE, HBURST, HPROT, HADDR, HWDATA,
    input  HREADY, HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HWRITE, HREADY, HMASTLOCK, HTRANS, HSIZE, HBURST, HPROT, HADDR, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_crypto_slave.sv
// AHB-Lite register front-end for the Triple DES core: keys, launch, result FIFO, irq.
// Define AHB_CRYPTO_STRICT_EN to reject non-word HSIZE, bursts, locked and SEQ transfers.
module ahb_crypto_slave #(
  parameter int unsigned       DATA_W       = 64,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       NUM_KEYS     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'hAAAA_AA80),
  parameter int unsigned       RESULT_DEPTH = 4
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  ahb_crypto_slave_if.slave          bus,
  output logic                       core_start,
  output logic                       core_mode,
  output logic [DATA_W-1:0]          core_data,
  output logic [NUM_KEYS*DATA_W-1:0] core_keys,
  input  logic                       core_done,
  input  logic [DATA_W-1:0]          core_result,
  output logic                       irq
);
  localparam int unsigned LSB   = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(NUM_KEYS + 4);
  localparam int unsigned HI    = LSB + IDX_W;
  localparam int unsigned PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESULT_DEPTH + 1);

  localparam logic [IDX_W-1:0] IDX_CTRL = '0;
  localparam logic [IDX_W-1:0] IDX_DIN  = IDX_W'(NUM_KEYS + 1);
  localparam logic [IDX_W-1:0] IDX_RES  = IDX_W'(NUM_KEYS + 2);
  localparam logic [IDX_W-1:0] IDX_STAT = IDX_W'(NUM_KEYS + 3);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_t;

  state_t                                 state_q, state_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic                                   wr_q, wr_d;
  logic                                   mode_q, mode_d;
  logic                                   ovf_q, ovf_d;
  logic                                   busy_q, busy_d;
  logic                                   start_q, start_d;
  logic                                   irq_q, irq_d;
  logic [DATA_W-1:0]                      data_q, data_d;
  logic [NUM_KEYS-1:0][DATA_W-1:0]        key_q, key_d;
  logic [RESULT_DEPTH-1:0][DATA_W-1:0]    fifo_q, fifo_d;
  logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;

  logic             dphase, dwr, launch, pop, push, push_ok, full, empty;
  logic [15:0]      status;
  logic [IDX_W-1:0] a_idx;
  logic             hit, accept, strict_bad, bad;
  logic             unused_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESULT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign dphase  = (state_q == S_ACCESS);
  assign dwr     = dphase & wr_q;
  assign launch  = dwr & (idx_q == IDX_DIN);
  assign pop     = dphase & ~wr_q & (idx_q == IDX_RES);
  // A strobe with no launch outstanding (e.g. after reset) is not ours to keep.
  assign push    = core_done & busy_q;
  assign full    = (cnt_q == CNT_W'(RESULT_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & (~full | pop);
  assign status  = {8'(cnt_q), 4'b0, full, empty, ovf_q, busy_q};

  always_comb begin : datapath
    mode_d   = mode_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    data_d   = data_q;
    key_d    = key_q;
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    start_d  = 1'b0;
    if (dwr) begin
      if (idx_q == IDX_CTRL) begin
        mode_d = bus.HWDATA[0];
        if (bus.HWDATA[1]) ovf_d = 1'b0;
      end
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (idx_q == IDX_W'(k + 1)) key_d[k] = bus.HWDATA;
      end
      if (launch) begin
        data_d  = bus.HWDATA;
        busy_d  = 1'b1;
        start_d = 1'b1;
      end
    end
    if (push) busy_d = 1'b0;
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_ok) begin
      fifo_d[wr_ptr_q] = core_result;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else if (push) begin
      ovf_d = 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
    irq_d = (cnt_d != '0);
  end

  // Legality is judged on busy/count as they will stand during the data phase.
  always_comb begin : fsm
    a_idx  = bus.HADDR[HI-1:LSB];
    hit    = (bus.HADDR[ADDR_W-1:HI] == BASE_ADDR[ADDR_W-1:HI]);
    accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hit & (state_q != S_ERR1);
`ifdef AHB_CRYPTO_STRICT_EN
    strict_bad = (bus.HSIZE != 3'(LSB)) | (bus.HBURST != 3'b000) | bus.HMASTLOCK |
                 (bus.HTRANS == 2'b11);
`else
    strict_bad = 1'b0;
`endif
    bad = (a_idx > IDX_STAT) |
          (bus.HWRITE & (a_idx <= IDX_DIN) & busy_d) |
          (~bus.HWRITE & (a_idx == IDX_RES) & (cnt_d == '0)) |
          strict_bad;
    state_d = (state_q == S_ERR1) ? S_ERR2 : S_IDLE;
    idx_d   = idx_q;
    wr_d    = wr_q;
    if (accept) begin
      idx_d   = a_idx;
      wr_d    = bus.HWRITE;
      state_d = bad ? S_ERR1 : S_ACCESS;
    end
  end

  always_comb begin : rdata
    bus.HRDATA = '0;
    if (dphase && !wr_q) begin
      case (idx_q)
        IDX_CTRL: bus.HRDATA = DATA_W'(mode_q);
        IDX_RES:  bus.HRDATA = fifo_q[rd_ptr_q];
        IDX_STAT: bus.HRDATA = DATA_W'(status);
        default:  bus.HRDATA = '0;
      endcase
    end
  end

  assign bus.HREADYOUT = (state_q != S_ERR1);
  assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      mode_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      data_q   <= '0;
      key_q    <= '0;
      fifo_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      mode_q   <= mode_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      irq_q    <= irq_d;
      data_q   <= data_d;
      key_q    <= key_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign core_start = start_q;
  assign core_mode  = mode_q;
  assign core_data  = data_q;
  assign core_keys  = key_q;
  assign irq        = irq_q;

  assign unused_bits = ^{bus.HPROT, bus.HSIZE, bus.HBURST, bus.HMASTLOCK, bus.HTRANS[0],
                         bus.HADDR[LSB-1:0]};
endmodule

// File: doc/ahb_crypto_slave.md
# ahb_crypto_slave

Parametrised AHB-Lite slave front-end for the Triple DES datapath, replacing the fixed single-key-set controller. It decodes a small register window (control, NUM_KEYS keys, data-in, result, status) with correct address/data-phase pipelining. It launches the cipher core with a start/done handshake and buffers core results in a RESULT_DEPTH-entry FIFO that the bus master drains. It also drives a level interrupt whenever results are pending.

## Interface
- DATA_W, 64: bus and block width; power of two, ≥32.
- ADDR_W, 32: HADDR width.
- NUM_KEYS, 3: number of key registers (1..8).
- BASE_ADDR, 32'hAAAA_AA80: window base; aligned to 2^IDX_W·(DATA_W/8) bytes, IDX_W = clog2(NUM_KEYS+4).
- RESULT_DEPTH, 4: result FIFO entries (≥1).
- HCLK  in  1  clock.
- HRESET  in  1  reset; one clock; reset is synchronous and active-high.
- HSEL, HWRITE, HREADY, HMASTLOCK  in  1  AHB-Lite controls.
- HTRANS  in  2; HSIZE, HBURST  in  3; HPROT  in  4  (HPROT unused).
- HADDR  in  ADDR_W; HWDATA  in  DATA_W.
- HRDATA  out  DATA_W; HREADYOUT  out  1; HRESP  out  1.
- core_start  out  1  one-cycle launch pulse.
- core_mode  out  1  1=encrypt, 0=decrypt.
- core_data  out  DATA_W; core_keys  out  NUM_KEYS·DATA_W (key k at bits [k·DATA_W +: DATA_W], k from 0).
- core_done  in  1  one-cycle result strobe; core_result  in  DATA_W.
- irq  out  1  high while FIFO non-empty.

## Operation
- Word index i = HADDR[LSB+IDX_W-1:LSB], LSB = clog2(DATA_W/8); upper bits must equal BASE_ADDR's, else transfer ignored (HSEL expected low).
- Map: i=0 CTRL (RW; bit0 mode; write bit1=1 clears overflow, reads 0); i=1..NUM_KEYS KEYk (write-only, read 0); NUM_KEYS+1 DATA_IN (write launches, read 0); NUM_KEYS+2 RESULT (RO, read pops FIFO head); NUM_KEYS+3 STATUS (RO: bit0 busy, bit1 overflow, bit2 empty, bit3 full, [15:8] count, rest 0); i>NUM_KEYS+3 unmapped.
- Writes to RESULT/STATUS ignored, OKAY.
- FSM: IDLE, ACCESS, ERR1, ERR2. Address phase accepted when HSEL & HREADY & HTRANS[1] and state≠ERR1; latches index/write/legal → ACCESS (or ERR1 if illegal). HTRANS IDLE/BUSY → IDLE, OKAY, no effect.
- Illegal: unmapped index; write to CTRL/KEY/DATA_IN while busy; read of RESULT while empty. Illegal transfers have no side effects.
- busy set on core_start, cleared on core_done. DATA_IN write: core_data captured, core_start next cycle.
- core_done pushes core_result; if full and no pop same cycle, result dropped, overflow set (sticky until CTRL clear or reset). Push and pop same cycle with full FIFO: both occur, no overflow.
- Reset: all registers, keys, mode, FIFO, busy, overflow cleared; HRDATA 0, HREADYOUT 1, HRESP 0, core_start 0, irq 0. Reset mid-operation abandons transfer and ignores later core_done for the lost launch (busy cleared).

## Timing
- OKAY transfers zero-wait: HREADYOUT=1 in data phase.
- Writes take HWDATA in the data-phase cycle; register updates on the edge ending it.
- Reads: HRDATA valid combinationally in data phase from latched index; FIFO pop on edge ending it; HRDATA 0 outside read data phases.
- Error: ERR1 HREADYOUT=0, HRESP=1; ERR2 HREADYOUT=1, HRESP=1; then IDLE or new address phase.
- Busy-check for writes uses busy during data phase; core_done in that same cycle still yields error.
- core_start exactly one cycle after DATA_IN write data phase; core_data/keys/mode stable while busy.
- irq registered from FIFO count, one cycle after push/pop.

## Configuration
- AHB_CRYPTO_STRICT_EN defined: HSIZE≠clog2(DATA_W/8), HBURST≠SINGLE, HMASTLOCK=1, or HTRANS=SEQ in an accepted address phase → two-cycle ERROR, no side effects.
- Undefined: those fields ignored; SEQ treated as NONSEQ.

## Test plan
- Reset, read STATUS (0x…AAB0) → HRDATA=0x04 (empty), OKAY, irq=0.
- Write CTRL=1, KEY1..3, DATA_IN=0x0123456789ABCDEF → core_start pulse one cycle after DATA_IN data phase, core_data matches, busy=1; core_done with 0xDEADBEEF00000000 → irq high; RESULT read returns it, then STATUS empty.
- Write KEY2 while busy → ERR1/ERR2 sequence, KEY2 unchanged; read RESULT while empty → error, count stays 0.
- Five launches/completions without reading (depth 4) → STATUS bit1=1, count=4, fifth dropped; CTRL write 0x2 clears bit1, FIFO intact; full FIFO with simultaneous pop and core_done → count stays 4, no overflow.
- Access offset 0x38 → error; with AHB_CRYPTO_STRICT_EN, HSIZE=2 write to KEY1 → error, without macro → OKAY and KEY1 updated.
- Assert HRESET while busy and FIFO holds 2 → all outputs reset values next cycle; late core_done not pushed.
